// File: rtl/guia_05_pkg.sv
// Shared constants for the guia 05 serial comparator exercises.
package guia_05_pkg;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Default operand width in bits.
  localparam int unsigned GUIA05_N = 4;

endpackage

// File: rtl/bit_gt_cell.sv
// Single-bit "a AND NOT b" cell built from two NOR gates.
module bit_gt_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o
);

  logic not_a;

  // NOR with tied inputs acts as the inverter; second NOR gives ~(~a | b) = a & ~b.
  assign not_a = ~(a_i | a_i);
  assign s_o   = ~(not_a | b_i);

endmodule

// File: rtl/guia_0502_serial_cmp.sv
// Serial MSB-first magnitude comparator: one bit of each operand per accepted cycle,
// first differing bit decides, result reported with a one-cycle done pulse after N bits.
module guia_0502_serial_cmp
  import guia_05_pkg::*;
#(
  parameter int unsigned N = GUIA05_N
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic gt,
  output logic lt,
  output logic eq
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            gt_q, gt_d;
  logic            lt_q, lt_d;
  logic            eq_q, eq_d;
  logic            busy_q, done_q;
  logic            g, l;

  // Per-bit greater-than in both directions.
  bit_gt_cell u_cell_gt (
    .a_i (a_bit),
    .b_i (b_bit),
    .s_o (g)
  );

  bit_gt_cell u_cell_lt (
    .a_i (b_bit),
    .b_i (a_bit),
    .s_o (l)
  );

  // Next-state logic for the FSM, bit counter and result flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
        end
      end
      SCAN: begin
        if (bit_valid) begin
          // Flags freeze once any bit has differed.
          if (!gt_q && !lt_q) begin
            gt_d = g;
            lt_d = l;
          end
          if (cnt_q == LastCnt) begin
            state_d = DONE;
            eq_d    = ~(gt_q | g) & ~(lt_q | l);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      busy_q  <= (state_d == SCAN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_guia_0502_serial_cmp.sv
// Bench for the serial comparator: directed cases plus randomized words, gaps and
// ignored-input noise, checked against an integer compare of the accepted operands.
module tb_guia_0502_serial_cmp;

  logic clk = 1'b0;
  logic rst, start, bit_valid, a_bit, b_bit;
  logic busy, done, gt, lt, eq;

  int n_assert = 0;
  int n_fail   = 0;

  guia_0502_serial_cmp #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  always #5 clk = ~clk;

  // Hard stop in case stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic eg, input logic el, input logic ee);
    check({tag, "_gt"}, gt, eg);
    check({tag, "_lt"}, lt, el);
    check({tag, "_eq"}, eq, ee);
  endtask

  // One full comparison. gaps[4k+:4] idle cycles precede the k-th bit (MSB is k=0).
  // With noise set, start and bit_valid are toggled where the design must ignore them.
  task automatic run_cmp(input logic [3:0] a, input logic [3:0] b, input logic [15:0] gaps,
                         input bit noise);
    logic eg, el, ee;
    int   ng;
    eg = (int'(a) > int'(b));
    el = (int'(a) < int'(b));
    ee = (int'(a) == int'(b));

    // Idle cycle, possibly with a stray valid bit.
    start = 1'b0; bit_valid = noise; a_bit = 1'($urandom); b_bit = 1'($urandom);
    step();
    check("idle_busy", busy, 1'b0);

    // Start edge, possibly with a coincident valid bit.
    start = 1'b1; bit_valid = noise; a_bit = 1'($urandom); b_bit = 1'($urandom);
    step();
    check("start_busy", busy, 1'b1);
    check("start_done", done, 1'b0);

    for (int k = 0; k < 4; k++) begin
      ng = int'(gaps[4*k +: 4]);
      for (int g = 0; g < ng; g++) begin
        start = noise ? 1'($urandom) : 1'b0;
        bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
        step();
        check("gap_busy", busy, 1'b1);
        check("gap_done", done, 1'b0);
      end
      start = noise ? 1'($urandom) : 1'b0;
      bit_valid = 1'b1; a_bit = a[3-k]; b_bit = b[3-k];
      step();
      if (k < 3) begin
        check("bit_busy", busy, 1'b1);
        check("bit_done", done, 1'b0);
      end else begin
        check("fin_done", done, 1'b1);
        check("fin_busy", busy, 1'b0);
        check_res("fin", eg, el, ee);
      end
    end

    // DONE cycle: start ignored, pulse must end.
    start = noise; bit_valid = noise; a_bit = 1'($urandom); b_bit = 1'($urandom);
    step();
    check("post_done", done, 1'b0);
    check("post_busy", busy, 1'b0);
    check_res("post", eg, el, ee);
    start = 1'b0; bit_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  ra, rb;
    logic [15:0] rg;

    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_res("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed cases.
    run_cmp(4'b1010, 4'b1001, 16'h0000, 1'b0);
    run_cmp(4'b0110, 4'b0111, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_done", done, 1'b0);
      check_res("hold", 1'b0, 1'b1, 1'b0);
    end
    run_cmp(4'b1111, 4'b1111, 16'h0000, 1'b0);
    run_cmp(4'b1000, 4'b0111, 16'h3120, 1'b0);

    // Abort after two accepted bits.
    start = 1'b1;
    step();
    start = 1'b0; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    step();
    step();
    rst = 1'b1; bit_valid = 1'b0;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check_res("abort", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_nodone", done, 1'b0);
    end
    run_cmp(4'b0011, 4'b0101, 16'h0000, 1'b0);

    // Randomized words, gaps and ignored-input noise.
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom);
      rb = (i % 4 == 0) ? ra : 4'($urandom);
      rg = {2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      run_cmp(ra, rb, rg, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
